uart_tx_fifo: RTL and testbench

Synthesizable UART transmitter that consumes the 9-bit `uart_out` bus produced by the RV32IM core and drives a serial line. The block replaces the simulation-only console printer in hardware builds.
- Each cycle the core asserts the strobe bit, the byte is pushed into a small FIFO.
- Bytes are serialized 8N1, LSB first, at `CLKS_PER_BIT` clocks per bit.
- Flags report busy, full and dropped bytes.

---
 rtl/uart_tx_fifo.sv | 194 +++++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: 8N1 UART transmitter fed by the core's 9-bit uart_out bus.
// Strobed bytes are queued in a small circular FIFO and sent LSB first.
// back-to-back frames follow each other with no idle cycle in between.
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic [8:0]                    uart_in,
  output logic                          tx,
  output logic                          busy,
  output logic                          full,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [15:0]   BC_LAST = 16'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  // FIFO storage and bookkeeping
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [CW-1:0] count_reg;
  logic          overflow_reg;

  // Serializer state
  state_t        state_reg;
  state_t        state_next;
  logic [15:0]   bc_reg;
  logic [15:0]   bc_next;
  logic [2:0]    bit_reg;
  logic [2:0]    bit_next;
  logic [7:0]    shift_reg;
  logic [7:0]    shift_next;
  logic          tx_reg;
  logic          tx_next;

  // Per-cycle handshake decisions
  logic          strobe;
  logic          fifo_empty;
  logic          fifo_full;
  logic          bit_end;
  logic          pop;
  logic          push;
  logic          drop;

  assign strobe     = uart_in[8];
  assign fifo_empty = (count_reg == '0);
  assign fifo_full  = (count_reg == DEPTH_C);
  assign bit_end    = (bc_reg == BC_LAST);

  // A pop loads the next frame: either from idle, or on the final stop
  // cycle so the next start bit follows with no gap.
  assign pop  = !fifo_empty &&
                ((state_reg == IDLE) || ((state_reg == STOP) && bit_end));
  // A full FIFO still accepts a byte when the head leaves on the same edge.
  assign push = strobe && (!fifo_full || pop);
  assign drop = strobe && !push;

  // FIFO data write; contents need no reset.
  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr_reg] <= uart_in[7:0];
    end
  end

  // FIFO pointers, occupancy and sticky overflow flag.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
      if (drop) begin
        overflow_reg <= 1'b1;
      end
    end
  end

  // Serializer next-state logic; tx is computed from the next state so the
  // line register changes on the same edge as the state.
  always_comb begin
    state_next = state_reg;
    bc_next    = bc_reg;
    bit_next   = bit_reg;
    shift_next = shift_reg;
    tx_next    = 1'b1;

    case (state_reg)
      IDLE: begin
        bc_next = '0;
        if (pop) begin
          state_next = START;
          shift_next = mem[rd_ptr_reg];
        end
      end

      START: begin
        if (bit_end) begin
          state_next = DATA;
          bc_next    = '0;
          bit_next   = '0;
        end else begin
          bc_next = bc_reg + 16'd1;
        end
      end

      DATA: begin
        if (bit_end) begin
          bc_next    = '0;
          shift_next = {1'b0, shift_reg[7:1]};
          bit_next   = bit_reg + 3'd1;
          if (bit_reg == 3'd7) begin
            state_next = STOP;
          end
        end else begin
          bc_next = bc_reg + 16'd1;
        end
      end

      STOP: begin
        if (bit_end) begin
          bc_next = '0;
          if (pop) begin
            state_next = START;
            shift_next = mem[rd_ptr_reg];
          end else begin
            state_next = IDLE;
          end
        end else begin
          bc_next = bc_reg + 16'd1;
        end
      end

      default: begin
        state_next = IDLE;
        bc_next    = '0;
      end
    endcase

    case (state_next)
      START:   tx_next = 1'b0;
      DATA:    tx_next = shift_next[0];
      default: tx_next = 1'b1;
    endcase
  end

  // Serializer state register; reset forces the line high immediately.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= IDLE;
      bc_reg    <= '0;
      bit_reg   <= '0;
      shift_reg <= '0;
      tx_reg    <= 1'b1;
    end else begin
      state_reg <= state_next;
      bc_reg    <= bc_next;
      bit_reg   <= bit_next;
      shift_reg <= shift_next;
      tx_reg    <= tx_next;
    end
  end

  assign tx       = tx_reg;
  assign busy     = (state_reg != IDLE) || !fifo_empty;
  assign full     = fifo_full;
  assign count    = count_reg;
  assign overflow = overflow_reg;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed scenarios plus random strobe traffic, every cycle
// compared against a frame-position reference model (byte queue + position
// inside a 10-bit frame).
module tb_uart_tx_fifo;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int FRAME = 10 * CPB;

  logic       clock   = 1'b0;
  logic       reset_n = 1'b1;
  logic [8:0] uart_in = '0;
  logic       tx;
  logic       busy;
  logic       full;
  logic [2:0] count;
  logic       overflow;

  uart_tx_fifo #(
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .uart_in (uart_in),
    .tx      (tx),
    .busy    (busy),
    .full    (full),
    .count   (count),
    .overflow(overflow)
  );

  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;

  // Reference model: pending bytes, the frame on the wire and its position.
  logic [7:0] q[$];
  bit         active = 1'b0;
  int         pos    = 0;
  logic [9:0] frame  = '1;
  bit         ovf    = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One rising edge of the reference: pop first (frees a slot), then push.
  task automatic model_edge(input bit strobe, input logic [7:0] d);
    bit pop;
    bit acc;
    logic [7:0] b;
    pop = (q.size() != 0) && (!active || pos == FRAME - 1);
    acc = strobe && ((q.size() < DEPTH) || pop);
    if (pop) begin
      b      = q.pop_front();
      frame  = {1'b1, b, 1'b0};
      active = 1'b1;
      pos    = 0;
    end else if (active) begin
      if (pos == FRAME - 1) active = 1'b0;
      else pos++;
    end
    if (strobe) begin
      if (acc) q.push_back(d);
      else ovf = 1'b1;
    end
  endtask

  task automatic check_all(input string ctx);
    logic exp_tx;
    exp_tx = active ? frame[pos / CPB] : 1'b1;
    check({ctx, ".tx"},       32'(tx),       32'(exp_tx));
    check({ctx, ".busy"},     32'(busy),     32'(active || q.size() != 0));
    check({ctx, ".count"},    32'(count),    32'(q.size()));
    check({ctx, ".full"},     32'(full),     32'(q.size() == DEPTH));
    check({ctx, ".overflow"}, 32'(overflow), 32'(ovf));
  endtask

  task automatic step(input string ctx, input bit s, input logic [7:0] d);
    uart_in = {s, d};
    @(posedge clock);
    model_edge(s, d);
    #1;
    uart_in = '0;
    check_all(ctx);
  endtask

  task automatic idle(input string ctx, input int n);
    for (int i = 0; i < n; i++) step(ctx, 1'b0, 8'h00);
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic do_reset(input string ctx);
    #2;
    reset_n = 1'b0;
    #1;
    check({ctx, ".rst_tx"},       32'(tx),       32'd1);
    check({ctx, ".rst_busy"},     32'(busy),     32'd0);
    check({ctx, ".rst_count"},    32'(count),    32'd0);
    check({ctx, ".rst_full"},     32'(full),     32'd0);
    check({ctx, ".rst_overflow"}, 32'(overflow), 32'd0);
    q.delete();
    active = 1'b0;
    pos    = 0;
    ovf    = 1'b0;
    #3;
    reset_n = 1'b1;
    step({ctx, ".post_rst"}, 1'b0, 8'h00);
  endtask

  initial begin
    bit found;
    int rate;
    #1;

    // Reset state and idle line
    do_reset("init");
    idle("idle", 200);

    // Single byte 'A'
    step("single", 1'b1, 8'h41);
    step("single", 1'b0, 8'h00);
    check("single.start_bit", 32'(tx), 32'd0);
    idle("single", FRAME + 5);
    check("single.busy_end", 32'(busy), 32'd0);

    // Back-to-back 'H','i'
    step("b2b", 1'b1, 8'h48);
    step("b2b", 1'b1, 8'h69);
    idle("b2b", 2 * FRAME + 5);

    // Overflow: six strobes into a depth-4 FIFO
    for (int i = 1; i <= 6; i++) step("ovf", 1'b1, 8'(i));
    check("ovf.full", 32'(full), 32'd1);
    check("ovf.sticky", 32'(overflow), 32'd1);
    idle("ovf", 6 * FRAME);
    check("ovf.sticky_after", 32'(overflow), 32'd1);

    // Push while full on the final stop cycle
    do_reset("pwf");
    step("pwf", 1'b1, 8'h11);
    for (int i = 0; i < 4; i++) step("pwf", 1'b1, 8'h21 + 8'(i));
    found = 1'b0;
    for (int i = 0; i < 2 * FRAME && !found; i++) begin
      if (active && pos == FRAME - 1) found = 1'b1;
      else step("pwf.wait", 1'b0, 8'h00);
    end
    check("pwf.reached_stop", 32'(found), 32'd1);
    step("pwf", 1'b1, 8'h7E);
    check("pwf.count_kept", 32'(count), 32'd4);
    check("pwf.no_overflow", 32'(overflow), 32'd0);
    idle("pwf", 5 * FRAME + 5);

    // Reset during data bit 3 of 0x55
    do_reset("mid");
    step("mid", 1'b1, 8'h55);
    found = 1'b0;
    for (int i = 0; i < 2 * FRAME && !found; i++) begin
      if (active && pos == 4 * CPB + 1) found = 1'b1;
      else step("mid.wait", 1'b0, 8'h00);
    end
    check("mid.reached_bit3", 32'(found), 32'd1);
    do_reset("mid");
    step("mid.after", 1'b1, 8'h0F);
    idle("mid.after", FRAME + 5);

    // Random strobe traffic at varying densities
    do_reset("rand");
    for (int seg = 0; seg < 10; seg++) begin
      rate = $urandom_range(1, 12);
      for (int i = 0; i < 300; i++) begin
        step("rand", ($urandom_range(0, 99) < rate * 3), 8'($urandom));
      end
    end
    idle("rand.drain", (DEPTH + 1) * FRAME + 5);
    check("rand.drained", 32'(busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
